// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding, owner constants and default widths for ram_arbiter.
package ram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACC, RESP} state_e;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;
  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner select; on a tie the port named by pref_i wins.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic cpu_req_i,
  input  logic dbg_req_i,
  input  logic pref_i,
  output logic win_o
);
  assign win_o = (cpu_req_i && dbg_req_i) ? pref_i : (dbg_req_i ? OWN_DBG : OWN_CPU);
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port single-RAM arbiter, 3-cycle IDLE/ACC/RESP transactions.
// Define RAM_ARB_RR_EN for round-robin tie breaking; default is fixed CPU priority.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              cpu_gnt_o,
  output logic              dbg_gnt_o,
  output logic              cpu_done_o,
  output logic              dbg_done_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_we_o,
  output logic              ram_re_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              busy_o,
  output logic              owner_o
);
  state_e              state_q, state_d;
  logic                own_q, we_q, win, pref, start;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, cpu_rdata_q, dbg_rdata_q;
`ifdef RAM_ARB_RR_EN
  logic rr_q;
  assign pref = rr_q;
  always_ff @(posedge clk_i)
    if (rst_i) rr_q <= OWN_CPU;
    else if (start) rr_q <= ~win;
`else
  assign pref = OWN_CPU;
`endif
  ram_arb_pick u_pick (
    .cpu_req_i(cpu_req_i),
    .dbg_req_i(dbg_req_i),
    .pref_i   (pref),
    .win_o    (win)
  );
  assign start = (state_q == IDLE) && (cpu_req_i || dbg_req_i);
  always_comb begin
    state_d = (state_q == ACC) ? RESP : (state_q == RESP) ? IDLE : (start ? ACC : IDLE);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      own_q       <= OWN_CPU;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) own_q <= win;
      // read data is captured at the end of ACC so it lines up with done
      if (state_q == ACC && !we_q && own_q == OWN_CPU) cpu_rdata_q <= ram_rdata_i;
      if (state_q == ACC && !we_q && own_q == OWN_DBG) dbg_rdata_q <= ram_rdata_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (start) begin
      we_q    <= win ? dbg_we_i : cpu_we_i;
      addr_q  <= win ? dbg_addr_i : cpu_addr_i;
      wdata_q <= win ? dbg_wdata_i : cpu_wdata_i;
    end
  end
  assign busy_o      = state_q != IDLE;
  assign owner_o     = own_q;
  assign cpu_gnt_o   = busy_o && own_q == OWN_CPU;
  assign dbg_gnt_o   = busy_o && own_q == OWN_DBG;
  assign cpu_done_o  = state_q == RESP && own_q == OWN_CPU;
  assign dbg_done_o  = state_q == RESP && own_q == OWN_DBG;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dbg_rdata_o = dbg_rdata_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign ram_we_o    = state_q == ACC && we_q;
  assign ram_re_o    = state_q == ACC && !we_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus random traffic against a transaction-level reference model.
module tb_ram_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  logic clk = 0, rst;
  logic cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr, ram_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, ram_wdata, ram_rdata;
  logic cpu_gnt, dbg_gnt, cpu_done, dbg_done, ram_we, ram_re, busy, owner;
  int total = 0, bad = 0;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  int phase;
  bit m_own, m_we, pref;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_rd [2];
  always #5 clk = ~clk;
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];
  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .cpu_gnt_o(cpu_gnt), .dbg_gnt_o(dbg_gnt), .cpu_done_o(cpu_done), .dbg_done_o(dbg_done),
    .cpu_rdata_o(cpu_rdata), .dbg_rdata_o(dbg_rdata),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_we_o(ram_we), .ram_re_o(ram_re),
    .ram_rdata_i(ram_rdata), .busy_o(busy), .owner_o(owner)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  // transaction-level model: phase 0 idle, 1 RAM access, 2 completion
  task automatic step();
    if (rst) begin
      if (phase == 1 && m_we) ref_mem[m_addr] = m_wd;
      phase = 0; m_own = 0; pref = 0; m_rd[0] = 0; m_rd[1] = 0;
    end else if (phase == 0) begin
      if (cpu_req || dbg_req) begin
        m_own = (cpu_req && dbg_req) ? pref : dbg_req;
`ifdef RAM_ARB_RR_EN
        pref = !m_own;
`endif
        m_we   = m_own ? dbg_we : cpu_we;
        m_addr = m_own ? dbg_addr : cpu_addr;
        m_wd   = m_own ? dbg_wdata : cpu_wdata;
        phase  = 1;
      end
    end else if (phase == 1) begin
      if (m_we) ref_mem[m_addr] = m_wd;
      else m_rd[m_own] = ref_mem[m_addr];
      phase = 2;
    end else phase = 0;
  endtask
  task automatic check_all();
    chk("busy", busy, phase != 0);
    chk("owner", owner, m_own);
    chk("ram_we", ram_we, phase == 1 && m_we);
    chk("ram_re", ram_re, phase == 1 && !m_we);
    chk("cpu_gnt", cpu_gnt, phase != 0 && !m_own);
    chk("dbg_gnt", dbg_gnt, phase != 0 && m_own);
    chk("cpu_done", cpu_done, phase == 2 && !m_own);
    chk("dbg_done", dbg_done, phase == 2 && m_own);
    chk("cpu_rdata", cpu_rdata, m_rd[0]);
    chk("dbg_rdata", dbg_rdata, m_rd[1]);
    if (phase == 1) chk("ram_addr", ram_addr, m_addr);
    if (phase == 1 && m_we) chk("ram_wdata", ram_wdata, m_wd);
  endtask
  task automatic tick();
    @(posedge clk);
    step();
    @(negedge clk);
    check_all();
  endtask
  task automatic reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask
  initial begin
    bit [0:3] exp_own;
    for (int i = 0; i < 2**AW; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    {cpu_req, cpu_we, dbg_req, dbg_we} = 0;
    cpu_addr = 0; dbg_addr = 0; cpu_wdata = 0; dbg_wdata = 0;
    phase = 0; m_own = 0; pref = 0; m_we = 0; m_addr = 0; m_wd = 0; m_rd[0] = 0; m_rd[1] = 0;
    @(negedge clk);
    reset();
    chk("rst_busy", busy, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    cpu_req = 1; cpu_we = 1; cpu_addr = 9'h005; cpu_wdata = 32'hDEADBEEF;
    tick(); cpu_req = 0;
    chk("wr_we", ram_we, 1);
    chk("wr_addr", ram_addr, 9'h005);
    tick();
    chk("wr_done", cpu_done, 1);
    chk("wr_we_off", ram_we, 0);
    tick();
    cpu_req = 1; cpu_we = 0;
    tick(); cpu_req = 0;
    tick();
    chk("rd_done", cpu_done, 1);
    chk("rd_data", cpu_rdata, 32'hDEADBEEF);
    chk("rd_dbg_data", dbg_rdata, 0);
    tick();
    reset();
`ifdef RAM_ARB_RR_EN
    exp_own = 4'b0101;
`else
    exp_own = 4'b0000;
`endif
    cpu_req = 1; dbg_req = 1; cpu_we = 0; dbg_we = 0; dbg_addr = 9'h005;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("tie_owner%0d", n), owner, exp_own[n]);
      tick(); tick();
    end
    cpu_req = 0; dbg_req = 0;
    tick();
    dbg_req = 1; dbg_we = 0; dbg_addr = 9'h1FF;
    tick(); dbg_req = 0; dbg_addr = 9'h000;
    #1 chk("dbg_addr_hold", ram_addr, 9'h1FF);
    tick();
    chk("dbg_done", dbg_done, 1);
    tick();
    chk("dbg_done_once", dbg_done, 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h005;
    tick(); tick(); cpu_req = 0; tick();
    cpu_req = 1;
    tick(); cpu_req = 0; rst = 1;
    chk("abort_acc", ram_re, 1);
    tick(); rst = 0;
    chk("abort_done", cpu_done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_re", ram_re, 0);
    chk("abort_rdata", cpu_rdata, 0);
    for (int c = 0; c < 800; c++) begin
      rst       = $urandom_range(0, 59) == 0;
      cpu_req   = $urandom_range(0, 2) != 0;
      dbg_req   = $urandom_range(0, 2) != 0;
      cpu_we    = $urandom_range(0, 1);
      dbg_we    = $urandom_range(0, 1);
      cpu_addr  = $urandom_range(0, 7) == 0 ? 9'h1FF : 9'($urandom_range(0, 15));
      dbg_addr  = 9'($urandom_range(0, 15));
      cpu_wdata = $urandom;
      dbg_wdata = $urandom;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
